data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request accept and response (legal range 0-15).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req_valid, input, width 1: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, width 1: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, width 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, width 32: the byte address.
REQ-009 The block SHALL have port req_wdata, input, width 32: the store data.
REQ-010 The block SHALL have port resp_valid, output, width 1: a response is present.
REQ-011 The block SHALL have port resp_ready, input, width 1: the initiator accepts the response.
REQ-012 The block SHALL have port resp_rdata, output, width 32: the load data, and 0 for stores and errors.
REQ-013 The block SHALL have port resp_err, output, width 1: the address is misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states (IDLE, WAIT, RESP); req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-015 A request SHALL be accepted at the rising edge where req_valid and req_ready are both 1; on that edge req_we, req_addr and req_wdata SHALL be latched, and later input changes SHALL have no effect.
REQ-016 On accept, the FSM SHALL go to WAIT with its cycle counter loaded to LATENCY-1 when LATENCY>0, or SHALL go directly to RESP when LATENCY=0.
REQ-017 In WAIT the counter SHALL decrement each cycle, and the edge where the counter equals 0 SHALL move the FSM to RESP; resp_valid therefore SHALL first be high exactly LATENCY+1 edges after the accepting edge.
REQ-018 The edge entering RESP SHALL perform the access once: a load SHALL register mem[addr[31:2]] into resp_rdata, and a store SHALL write the latched wdata to mem[addr[31:2]] and set resp_rdata=0.
REQ-019 An address with addr[1:0]!=0, or with addr[31:2]>=DEPTH_WORDS, SHALL set resp_err=1, SHALL not modify storage, SHALL return resp_rdata=0, and SHALL still follow the normal latency.
REQ-020 resp_valid, resp_rdata and resp_err SHALL hold stable in RESP until an edge with resp_ready=1; that edge SHALL return the FSM to IDLE, so req_ready=1 in the following cycle.
REQ-021 Back-to-back requests SHALL incur exactly one IDLE cycle between the response handshake and the next accept, with no request pipelining or overlap.
REQ-022 A load following a store to the same word SHALL return the newly stored value.
REQ-023 req_valid asserted outside IDLE SHALL be ignored until IDLE and SHALL NOT be dropped if still held.
REQ-024 Storage SHALL be word-addressed only, with no byte enables, and the address SHALL NOT wrap: out-of-range addresses are errors, never aliased.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, counter=0, req_ready=1 (from the next cycle), resp_valid=0, resp_rdata=0, and resp_err=0.
REQ-026 Reset SHALL NOT clear storage contents.
REQ-027 Reset in WAIT or RESP SHALL abort the transaction; a store aborted before reaching RESP SHALL NOT be written, and a store already performed SHALL remain written.
REQ-028 Reset SHALL take priority over every handshake event on the same edge.

Verification
REQ-029 Store then load (LATENCY=2): store 0xDEADBEEF to 0x10, then load 0x10 -> resp_valid rises 3 edges after each accept; the load returns 0xDEADBEEF with resp_err=0.
REQ-030 Response backpressure: hold resp_ready=0 for 5 cycles after resp_valid on a load of 0x20 preloaded with 0x12345678 -> resp_rdata stays 0x12345678 and resp_valid stays 1; req_ready=1 one cycle after resp_ready=1.
REQ-031 Error cases: load 0x13 and store to 4*DEPTH_WORDS (0x1000) -> resp_err=1 and resp_rdata=0; a subsequent load of word 0 returns its prior value unchanged.
REQ-032 LATENCY=0 build: accept a load of 0x4 -> resp_valid=1 on the edge right after accept; with resp_ready held 1, the next accept occurs 2 edges later.
REQ-033 Reset mid-WAIT: a store of 0xCAFEF00D to 0x8 with reset asserted 1 cycle after accept -> resp_valid=0 and req_ready=1 after reset; a load of 0x8 returns the old value.
REQ-034 Input churn: change req_addr and req_wdata during WAIT -> the response reflects the values latched at accept.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each accepted request is answered after a fixed LATENCY. Only one request
// is in flight at a time.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic        ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_idle;
  logic             w_accept;
  logic             w_enter_resp;
  logic             w_acc_we;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic [29:0]      w_word;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_mem_we;
  logic [31:0]      w_rd;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & req_valid;

  // With zero latency the access happens on the accepting edge itself, so the
  // live request inputs are used; otherwise the values latched at accept.
  assign w_enter_resp = (w_accept & ZERO_LAT) | ((r_state == S_WAIT) & (r_cnt == 4'd0));
  assign w_acc_we     = w_idle ? req_we    : r_we;
  assign w_acc_addr   = w_idle ? req_addr  : r_addr;
  assign w_acc_wdata  = w_idle ? req_wdata : r_wdata;

  assign w_word = w_acc_addr[31:2];
  // Out-of-range words are errors rather than aliases of low words.
  assign w_err  = (w_acc_addr[1:0] != 2'b00) | ({2'b00, w_word} >= 32'(DEPTH_WORDS));
  assign w_idx  = w_word[IDX_W-1:0];
  assign w_rd   = r_mem[w_idx];

  // Reset gates the write so a store aborted on the same edge never lands.
  assign w_mem_we = w_enter_resp & w_acc_we & ~w_err & ~reset;

  // Storage: word write on the edge entering RESP; never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  // Control FSM, request latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (ZERO_LAT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_acc_we) ? 32'd0 : w_rd;
      end
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance driven through a
// scoreboard of expected responses, plus a LATENCY=0 instance for timing.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  logic [31:0] model [int];

  data_mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(0)) u_dut_z (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (z_req_valid),
    .req_ready  (z_req_ready),
    .req_we     (z_req_we),
    .req_addr   (z_req_addr),
    .req_wdata  (z_req_wdata),
    .resp_valid (z_resp_valid),
    .resp_ready (z_resp_ready),
    .resp_rdata (z_resp_rdata),
    .resp_err   (z_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance. The expected response is
  // pushed when the request is driven and popped when resp_valid appears.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int bp, input bit churn);
    exp_t e;
    int   n;
    int   lat;
    e.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= Depth);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we) model[int'(addr >> 2)] = wdata;
      else    e.rdata = model[int'(addr >> 2)];
    end
    sb_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);  // accepting edge
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      if (churn) begin
        req_addr  = addr ^ 32'h40;
        req_wdata = ~wdata;
        req_we    = ~we;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(Lat + 1));
    e = sb_q.pop_front();
    check("rdata", resp_rdata, e.rdata);
    check("err", 32'(resp_err), 32'(e.err));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, e.rdata);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    check("post_hs_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    z_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);

    // Store then load.
    send(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    send(1'b0, 32'h10, 32'h0, 0, 1'b0);
    // Backpressure on a preloaded word.
    send(1'b1, 32'h20, 32'h12345678, 0, 1'b0);
    send(1'b0, 32'h20, 32'h0, 5, 1'b0);
    // Error cases leave storage alone.
    send(1'b1, 32'h0, 32'hA5A50001, 0, 1'b0);
    send(1'b0, 32'h13, 32'h0, 0, 1'b0);
    send(1'b1, 32'h1000, 32'hFFFFFFFF, 0, 1'b0);
    send(1'b0, 32'h0, 32'h0, 0, 1'b0);
    // Input churn during WAIT.
    send(1'b1, 32'h30, 32'h00000055, 0, 1'b1);
    send(1'b0, 32'h30, 32'h0, 0, 1'b1);
    send(1'b0, 32'h70, 32'h0, 0, 1'b0);  // churned address must not have been written

    // Zero-latency instance: response right after accept; request held across
    // RESP is taken two edges after the first accept.
    @(negedge clk);
    z_resp_ready = 1'b1;
    z_req_valid  = 1'b1;
    z_req_we     = 1'b1;
    z_req_addr   = 32'h4;
    z_req_wdata  = 32'h0BADCAFE;
    check("z_ready_idle", 32'(z_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("z_valid_after_accept", 32'(z_resp_valid), 32'd1);
    check("z_store_rdata", z_resp_rdata, 32'd0);
    z_req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("z_idle_ready", 32'(z_req_ready), 32'd1);
    check("z_idle_valid", 32'(z_resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    check("z_load_valid", 32'(z_resp_valid), 32'd1);
    check("z_load_rdata", z_resp_rdata, 32'h0BADCAFE);
    check("z_load_err", 32'(z_resp_err), 32'd0);
    @(negedge clk);
    z_resp_ready = 1'b0;
    check("z_end_ready", 32'(z_req_ready), 32'd1);

    // Reset one cycle after accepting a store aborts it.
    send(1'b1, 32'h8, 32'h11111111, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_ready", 32'(n < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rdata", resp_rdata, 32'd0);
    check("abort_err", 32'(resp_err), 32'd0);
    send(1'b0, 32'h8, 32'h0, 0, 1'b0);
    send(1'b0, 32'h10, 32'h0, 0, 1'b0);  // storage survives reset

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
